// File: rtl/regfile_writeback_ctrl.sv
// Register-file writeback controller: ALU/load results queue in an in-order FIFO and retire one per cycle.
// Optional WB_FWD_EN adds youngest-match forwarding outputs alongside the busy scoreboard.
module regfile_writeback_ctrl #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   output logic        alu_ready,
   input  logic        ld_valid,
   input  logic [4:0]  ld_rd,
   input  logic [31:0] ld_data,
   output logic        ld_ready,
   input  logic [4:0]  q_rs1,
   input  logic [4:0]  q_rs2,
   output logic        busy_rs1,
   output logic        busy_rs2,
   output logic        rf_we,
   output logic [4:0]  rf_w,
   output logic [31:0] rf_wdata,
`ifdef WB_FWD_EN
   output logic        fwd_rs1_valid,
   output logic [31:0] fwd_rs1_data,
   output logic        fwd_rs2_valid,
   output logic [31:0] fwd_rs2_data,
`endif
   output logic        empty
);

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_entry_t;

   wb_entry_t   mem [DEPTH];
   wb_entry_t   enq_entry;
   logic [AW:0] wr_ptr, rd_ptr, count;
   logic        full, fifo_empty, ld_acc, alu_acc, enq;

   assign count      = wr_ptr - rd_ptr;
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // Readiness looks only at full, never at a same-cycle dequeue.
   assign ld_ready  = !reset && !full;
   assign alu_ready = !reset && !full && !ld_valid;
   assign ld_acc    = ld_valid && ld_ready;
   assign alu_acc   = alu_valid && alu_ready;
   assign empty     = fifo_empty && !rf_we;

   always_comb begin
      enq       = 1'b0;
      enq_entry = '{rd: alu_rd, data: alu_data};
      if (ld_acc) begin
         enq       = (ld_rd != 5'd0);
         enq_entry = '{rd: ld_rd, data: ld_data};
      end else if (alu_acc) begin
         enq = (alu_rd != 5'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         rf_we    <= 1'b0;
         rf_w     <= '0;
         rf_wdata <= '0;
      end else begin
         if (enq) begin
            mem[wr_ptr[AW-1:0]] <= enq_entry;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (!fifo_empty) begin
            rf_we    <= 1'b1;
            rf_w     <= mem[rd_ptr[AW-1:0]].rd;
            rf_wdata <= mem[rd_ptr[AW-1:0]].data;
            rd_ptr   <= rd_ptr + 1'b1;
         end else begin
            rf_we <= 1'b0;
         end
      end
   end

   // Scan oldest to youngest so the last match is the youngest; the landing write is oldest of all.
   logic [1:0][4:0] q;
   logic [1:0]      hit;
   logic [AW-1:0]   idx;
`ifdef WB_FWD_EN
   logic [1:0][31:0] hit_data;
`endif
   assign q = {q_rs2, q_rs1};

   always_comb begin
      hit = '0;
      idx = '0;
`ifdef WB_FWD_EN
      hit_data = '0;
`endif
      for (int p = 0; p < 2; p++) begin
         hit[p] = rf_we && (rf_w == q[p]);
`ifdef WB_FWD_EN
         hit_data[p] = rf_wdata;
`endif
         for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr[AW-1:0] + AW'(i);
            if (((AW+1)'(i) < count) && (mem[idx].rd == q[p])) begin
               hit[p] = 1'b1;
`ifdef WB_FWD_EN
               hit_data[p] = mem[idx].data;
`endif
            end
         end
         if (q[p] == 5'd0) hit[p] = 1'b0;
      end
   end

   assign busy_rs1 = hit[0];
   assign busy_rs2 = hit[1];
`ifdef WB_FWD_EN
   assign fwd_rs1_valid = hit[0];
   assign fwd_rs1_data  = hit_data[0];
   assign fwd_rs2_valid = hit[1];
   assign fwd_rs2_data  = hit_data[1];
`endif

endmodule
